// File: rtl/mult_iter.sv
// Iterative radix-2 shift-add multiplier, signed or unsigned, with a start/busy/done handshake.
// Signed operands are converted to magnitudes, multiplied, then the sign is reapplied.
module mult_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] z
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] z_q, z_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   a_mag, b_mag;

  // Magnitude of the most negative value wraps to 2^(WIDTH-1), which is correct unsigned.
  always_comb begin
    a_mag = (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    b_mag = (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    z_d      = z_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    done_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
          neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mplier_d = mplier_q >> 1;
        mcand_d  = mcand_q << 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LastIter) begin
          state_d = StFinish;
        end
      end
      StFinish: begin
        z_d     = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      acc_q    <= '0;
      z_q      <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      z_q      <= z_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign z    = z_q;

endmodule

// File: tb/tb_mult_iter.sv
// Bench for mult_iter: directed and random multiplies on WIDTH=32 and WIDTH=8 instances,
// checked against an arithmetic product model with latency and handshake checks.
module tb_mult_iter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start32, sm32, busy32, done32;
  logic [31:0] a32, b32;
  logic [63:0] z32;
  logic        start8, sm8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] z8;

  bit          cur_w8;
  logic        busy_s, done_s;
  logic [63:0] z_s;
  logic [63:0] exp_z;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mult_iter #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .signed_mode(sm32),
    .a(a32), .b(b32), .busy(busy32), .done(done32), .z(z32)
  );

  mult_iter #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .signed_mode(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .z(z8)
  );

  assign busy_s = cur_w8 ? busy8 : busy32;
  assign done_s = cur_w8 ? done8 : done32;
  assign z_s    = cur_w8 ? {48'b0, z8} : z32;

  // Reference product from plain integer arithmetic, truncated to the result width.
  function automatic logic [63:0] model(input bit w8, input bit sm, input logic [31:0] x,
                                        input logic [31:0] y);
    longint      sx, sy;
    logic [63:0] p;
    byte         xb, yb;
    int          xi, yi;
    xb = x[7:0];
    yb = y[7:0];
    xi = x;
    yi = y;
    if (w8) begin
      sx = sm ? longint'(xb) : longint'({56'b0, x[7:0]});
      sy = sm ? longint'(yb) : longint'({56'b0, y[7:0]});
    end else begin
      sx = sm ? longint'(xi) : longint'({32'b0, x});
      sy = sm ? longint'(yi) : longint'({32'b0, y});
    end
    p = sx * sy;
    return w8 ? {48'b0, p[15:0]} : p;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive a start at a negedge; returns just after the accepting edge with inputs scrambled.
  task automatic issue(input bit w8, input bit sm, input logic [31:0] x, input logic [31:0] y);
    cur_w8 = w8;
    exp_z  = model(w8, sm, x, y);
    if (w8) begin
      start8 = 1'b1; sm8 = sm; a8 = x[7:0]; b8 = y[7:0];
    end else begin
      start32 = 1'b1; sm32 = sm; a32 = x; b32 = y;
    end
    @(negedge clk);
    start8  = 1'b0;
    start32 = 1'b0;
    a32 = $urandom; b32 = $urandom; sm32 = 1'($urandom);
    a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
    check("busy_after_start", 64'(busy_s), 64'd1);
  endtask

  task automatic finish_op(input int elapsed, input string tag);
    int lat;
    int explat;
    lat    = elapsed;
    explat = cur_w8 ? 9 : 33;
    while (!done_s && lat < 80) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_done"}, 64'(done_s), 64'd1);
    check({tag, "_lat"}, 64'(lat), 64'(explat));
    check({tag, "_z"}, z_s, exp_z);
    check({tag, "_busy_low"}, 64'(busy_s), 64'd0);
  endtask

  task automatic settle(input string tag);
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done_s), 64'd0);
    check({tag, "_z_hold"}, z_s, exp_z);
  endtask

  initial begin
    logic [31:0] rx, ry;
    bit          rs;
    int          saw;
    reset = 1'b0;
    start32 = 1'b0; sm32 = 1'b0; a32 = '0; b32 = '0;
    start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    cur_w8 = 1'b0;
    exp_z = '0;

    repeat (3) begin
      @(negedge clk);
      check("rst_z", z32, 64'd0);
      check("rst_done", 64'(done32), 64'd0);
      check("rst_busy", 64'(busy32), 64'd0);
    end
    reset = 1'b1;
    @(negedge clk);

    issue(0, 0, 32'd10, 32'd10);
    finish_op(0, "u10x10");
    check("u10x10_const", z32, 64'd100);
    settle("u10x10");

    issue(0, 0, 32'd20, 32'd20);
    finish_op(0, "u20x20");
    issue(0, 0, 32'd100, 32'd100);
    finish_op(0, "u100x100");
    check("u100x100_const", z32, 64'd10000);
    settle("u100x100");
    issue(0, 0, 32'd0, 32'd50);
    finish_op(0, "u0x50");
    settle("u0x50");

    issue(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_op(0, "umax");
    check("umax_const", z32, 64'hFFFF_FFFE_0000_0001);
    issue(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_op(0, "sneg1");
    check("sneg1_const", z32, 64'd1);
    settle("sneg1");

    issue(0, 1, 32'hFFFF_FFFD, 32'd5);
    finish_op(0, "sm3x5");
    check("sm3x5_const", z32, 64'hFFFF_FFFF_FFFF_FFF1);
    issue(0, 1, 32'h8000_0000, 32'h8000_0000);
    finish_op(0, "sminmin");
    check("sminmin_const", z32, 64'h4000_0000_0000_0000);
    issue(0, 1, 32'h8000_0000, 32'd1);
    finish_op(0, "smin1");
    check("smin1_const", z32, 64'hFFFF_FFFF_8000_0000);
    settle("smin1");

    // A start mid-operation must be dropped and the original result arrive on schedule.
    issue(0, 0, 32'd7, 32'd9);
    repeat (9) @(negedge clk);
    start32 = 1'b1; sm32 = 1'b1; a32 = 32'd123; b32 = 32'hFFFF_0000;
    @(negedge clk);
    start32 = 1'b0;
    finish_op(10, "ignored_start");
    check("ignored_start_const", z32, 64'd63);
    settle("ignored_start");

    issue(0, 0, 32'd1000, 32'd1000);
    repeat (14) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_z", z32, 64'd0);
    check("abort_busy", 64'(busy32), 64'd0);
    check("abort_done", 64'(done32), 64'd0);
    reset = 1'b1;
    saw = 0;
    repeat (40) begin
      @(negedge clk);
      if (done32) saw++;
    end
    check("abort_no_done", 64'(saw), 64'd0);
    issue(0, 1, 32'hFFFF_FFF9, 32'd6);
    finish_op(0, "post_reset");
    settle("post_reset");

    for (int i = 0; i < 8; i++) begin
      rx = (i % 4 == 0) ? 32'h8000_0000 : $urandom;
      ry = $urandom;
      rs = 1'($urandom);
      issue(0, rs, rx, ry);
      finish_op(0, "rand32");
      if (i % 2 == 0) settle("rand32");
    end

    @(negedge clk);
    issue(1, 0, 32'd10, 32'd10);
    finish_op(0, "w8_u10x10");
    check("w8_u10x10_const", z_s, 64'd100);
    settle("w8_u10x10");
    issue(1, 1, 32'h80, 32'h80);
    finish_op(0, "w8_sminmin");
    check("w8_sminmin_const", z_s, 64'h4000);
    for (int i = 0; i < 8; i++) begin
      rx = $urandom;
      ry = $urandom;
      rs = 1'($urandom);
      issue(1, rs, rx, ry);
      finish_op(0, "rand8");
      if (i % 2 == 1) settle("rand8");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
